// File: rtl/inst_buffer_mq_pkg.sv
// Shared default sizing for the predecode->decode instruction buffer.
// Build with IBUF_BYPASS_EN defined to enable the same-cycle empty-queue bypass.
package inst_buffer_mq_pkg;

   localparam int IBUF_DEPTH      = 32;
   localparam int IBUF_ENQ_WIDTH  = 8;
   localparam int IBUF_DEQ_WIDTH  = 4;
   localparam int IBUF_INST_WIDTH = 32;
   localparam int IBUF_IDX_WIDTH  = 4;

endpackage

// File: rtl/inst_buffer_mq_compact.sv
// Prefix-popcount compaction: for each dense position k, src[k] is the slot
// holding the k-th set bit of mask; total is the number of set bits.
module inst_buffer_mq_compact
   import inst_buffer_mq_pkg::*;
#(
   parameter int W  = IBUF_ENQ_WIDTH,
   parameter int SW = $clog2(W),
   parameter int CW = $clog2(W) + 1
)(
   input  logic [W-1:0]          mask,
   output logic [W-1:0][SW-1:0]  src,
   output logic [CW-1:0]         total
);

   logic [W-1:0][CW-1:0] prefix;

   always_comb begin : p_prefix
      logic [CW-1:0] acc;
      acc = '0;
      for (int i = 0; i < W; i++) begin
         prefix[i] = acc;
         acc = acc + CW'(mask[i]);
      end
      total = acc;
   end

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_src
         always_comb begin
            src[gi] = '0;
            for (int i = 0; i < W; i++) begin
               if (mask[i] && (prefix[i] == CW'(gi)))
                  src[gi] = SW'(i);
            end
         end
      end
   endgenerate

endmodule

// File: rtl/inst_buffer_mq.sv
// Instruction buffer: compacts sparse predecode blocks into a circular queue
// and presents in-order groups to decode. Optional bypass: IBUF_BYPASS_EN.
module inst_buffer_mq
   import inst_buffer_mq_pkg::*;
#(
   parameter int DEPTH      = IBUF_DEPTH,
   parameter int ENQ_WIDTH  = IBUF_ENQ_WIDTH,
   parameter int DEQ_WIDTH  = IBUF_DEQ_WIDTH,
   parameter int INST_WIDTH = IBUF_INST_WIDTH,
   parameter int IDX_WIDTH  = IBUF_IDX_WIDTH
)(
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   flush,
   input  logic [ENQ_WIDTH-1:0]                   enq_en,
   input  logic [ENQ_WIDTH*INST_WIDTH-1:0]        enq_inst,
   input  logic [IDX_WIDTH-1:0]                   enq_fsqIdx,
   output logic                                   enq_ready,
   output logic [DEQ_WIDTH-1:0]                   deq_valid,
   output logic [DEQ_WIDTH*INST_WIDTH-1:0]        deq_inst,
   output logic [DEQ_WIDTH*IDX_WIDTH-1:0]         deq_fsqIdx,
   output logic [DEQ_WIDTH*$clog2(ENQ_WIDTH)-1:0] deq_offset,
   input  logic                                   deq_ready,
   output logic [$clog2(DEPTH):0]                 count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int OW = $clog2(ENQ_WIDTH);
   localparam int CW = OW + 1;

   typedef struct packed {
      logic [INST_WIDTH-1:0] inst;
      logic [IDX_WIDTH-1:0]  fsq_idx;
      logic [OW-1:0]         offset;
   } ibuf_entry_t;

   ibuf_entry_t mem [DEPTH];

   logic [PW-1:0]                head_reg, head_next;
   logic [PW-1:0]                tail_reg, tail_next;
   logic [PW-1:0]                count_next;
   logic                         enq_ready_reg, enq_ready_next;
   logic                         enq_fire, deq_fire, bypass;
   logic [CW-1:0]                enq_num;
   logic [ENQ_WIDTH-1:0][OW-1:0] enq_src;
   logic [PW-1:0]                avail, deq_num, skip;
   ibuf_entry_t                  slot_entry [ENQ_WIDTH];
   ibuf_entry_t                  deq_entry  [DEQ_WIDTH];
   logic [AW-1:0]                wr_addr    [ENQ_WIDTH];
   logic [AW-1:0]                rd_addr    [DEQ_WIDTH];

   inst_buffer_mq_compact #(.W(ENQ_WIDTH)) u_compact (
      .mask  (enq_en),
      .src   (enq_src),
      .total (enq_num)
   );

   // Pointers carry a wrap bit, so the difference is the exact occupancy 0..DEPTH.
   assign count     = tail_reg - head_reg;
   assign enq_ready = enq_ready_reg;
   assign enq_fire  = (|enq_en) & enq_ready_reg & ~flush;

`ifdef IBUF_BYPASS_EN
   assign bypass = enq_fire & (count == '0);
`else
   assign bypass = 1'b0;
`endif

   assign avail    = bypass ? PW'(enq_num) : count;
   assign deq_num  = (avail > PW'(DEQ_WIDTH)) ? PW'(DEQ_WIDTH) : avail;
   assign deq_fire = deq_ready & deq_valid[0] & ~flush;
   // Entries handed straight to decode by the bypass are never written.
   assign skip     = (bypass & deq_fire) ? deq_num : '0;

   genvar gi;
   generate
      for (gi = 0; gi < ENQ_WIDTH; gi++) begin : g_slot
         assign slot_entry[gi] = '{inst:    enq_inst[gi*INST_WIDTH +: INST_WIDTH],
                                   fsq_idx: enq_fsqIdx,
                                   offset:  OW'(gi)};
         assign wr_addr[gi]    = tail_reg[AW-1:0] + AW'(gi) - skip[AW-1:0];
      end

      for (gi = 0; gi < DEQ_WIDTH; gi++) begin : g_deq
         assign rd_addr[gi]   = head_reg[AW-1:0] + AW'(gi);
         assign deq_valid[gi] = PW'(gi) < avail;
         if (gi < ENQ_WIDTH) begin : g_byp
            assign deq_entry[gi] = bypass ? slot_entry[enq_src[gi]] : mem[rd_addr[gi]];
         end else begin : g_mem
            assign deq_entry[gi] = mem[rd_addr[gi]];
         end
         assign deq_inst[gi*INST_WIDTH +: INST_WIDTH] = deq_entry[gi].inst;
         assign deq_fsqIdx[gi*IDX_WIDTH +: IDX_WIDTH] = deq_entry[gi].fsq_idx;
         assign deq_offset[gi*OW +: OW]               = deq_entry[gi].offset;
      end
   endgenerate

   always_comb begin
      head_next = head_reg;
      tail_next = tail_reg;
      if (flush) begin
         head_next = '0;
         tail_next = '0;
      end else begin
         if (enq_fire)
            tail_next = tail_reg + PW'(enq_num) - skip;
         if (deq_fire && !bypass)
            head_next = head_reg + deq_num;
      end
      count_next     = tail_next - head_next;
      enq_ready_next = count_next <= PW'(DEPTH - ENQ_WIDTH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_reg      <= '0;
         tail_reg      <= '0;
         enq_ready_reg <= 1'b1;
      end else begin
         head_reg      <= head_next;
         tail_reg      <= tail_next;
         enq_ready_reg <= enq_ready_next;
      end
   end

   // Dense position k lands at tail+k; a dequeued slot is never a written one.
   always_ff @(posedge clk) begin
      if (enq_fire) begin
         for (int k = 0; k < ENQ_WIDTH; k++) begin
            if ((PW'(k) < PW'(enq_num)) && (PW'(k) >= skip))
               mem[wr_addr[k]] <= slot_entry[enq_src[k]];
         end
      end
   end

endmodule

// File: tb/tb_inst_buffer_mq.sv
// Self-checking bench for inst_buffer_mq: hand-derived vector table, directed
// wrap/bypass/reset sequences and randomized traffic against a queue model.
module tb_inst_buffer_mq;

   localparam int DEPTH = 32;
   localparam int ENQ   = 8;
   localparam int DEQ   = 4;
   localparam int IW    = 32;
   localparam int XW    = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              flush = 1'b0;
   logic              deq_ready = 1'b0;
   logic [ENQ-1:0]    enq_en = '0;
   logic [ENQ*IW-1:0] enq_inst = '0;
   logic [XW-1:0]     enq_fsqIdx = '0;
   logic              enq_ready;
   logic [DEQ-1:0]    deq_valid;
   logic [DEQ*IW-1:0] deq_inst;
   logic [DEQ*XW-1:0] deq_fsqIdx;
   logic [DEQ*3-1:0]  deq_offset;
   logic [5:0]        count;

   inst_buffer_mq dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .enq_en     (enq_en),
      .enq_inst   (enq_inst),
      .enq_fsqIdx (enq_fsqIdx),
      .enq_ready  (enq_ready),
      .deq_valid  (deq_valid),
      .deq_inst   (deq_inst),
      .deq_fsqIdx (deq_fsqIdx),
      .deq_offset (deq_offset),
      .deq_ready  (deq_ready),
      .count      (count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [IW-1:0] inst;
      logic [XW-1:0] fsq;
      logic [2:0]    off;
   } ent_t;

   ent_t q[$];
   ent_t comp[$];
   ent_t shown[$];
   bit   ready_m = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   drops = 0;

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic build_comp();
      ent_t e;
      comp.delete();
      for (int s = 0; s < ENQ; s++) begin
         if (enq_en[s]) begin
            e.inst = enq_inst[s*IW +: IW];
            e.fsq  = enq_fsqIdx;
            e.off  = 3'(s);
            comp.push_back(e);
         end
      end
   endtask

   // What decode should see this cycle, from the model queue and current inputs.
   task automatic compute_shown();
      build_comp();
      shown.delete();
`ifdef IBUF_BYPASS_EN
      if (q.size() == 0 && enq_en != '0 && ready_m && !flush) begin
         for (int i = 0; i < comp.size() && i < DEQ; i++) shown.push_back(comp[i]);
         return;
      end
`endif
      for (int i = 0; i < q.size() && i < DEQ; i++) shown.push_back(q[i]);
   endtask

   task automatic check_model();
      logic [DEQ-1:0] exp_v;
      compute_shown();
      chk("count", count, q.size());
      chk("enq_ready", enq_ready, ready_m);
      exp_v = '0;
      for (int i = 0; i < shown.size(); i++) exp_v[i] = 1'b1;
      chk("deq_valid", deq_valid, exp_v);
      for (int i = 0; i < shown.size(); i++) begin
         chk($sformatf("deq_inst[%0d]", i),   deq_inst[i*IW +: IW],   shown[i].inst);
         chk($sformatf("deq_fsqIdx[%0d]", i), deq_fsqIdx[i*XW +: XW], shown[i].fsq);
         chk($sformatf("deq_offset[%0d]", i), deq_offset[i*3 +: 3],   shown[i].off);
      end
   endtask

   task automatic update_model();
      int n;
      compute_shown();
      n = shown.size();
      if (flush) begin
         q.delete();
         ready_m = 1'b1;
      end else begin
         if (enq_en != '0 && !ready_m) drops++;
         if (enq_en != '0 && ready_m)
            foreach (comp[i]) q.push_back(comp[i]);
         if (deq_ready && n > 0)
            repeat (n) void'(q.pop_front());
         ready_m = (DEPTH - q.size()) >= ENQ;
      end
   endtask

   task automatic drive(input logic fl, input logic [ENQ-1:0] en, input logic dr,
                        input logic [XW-1:0] fsq, input logic [IW-1:0] base);
      flush      = fl;
      enq_en     = en;
      deq_ready  = dr;
      enq_fsqIdx = fsq;
      for (int s = 0; s < ENQ; s++) enq_inst[s*IW +: IW] = base + IW'(s);
      @(negedge clk);
      check_model();
   endtask

   task automatic advance();
      @(posedge clk);
      update_model();
      #1;
   endtask

   task automatic step(input logic fl, input logic [ENQ-1:0] en, input logic dr,
                       input logic [XW-1:0] fsq, input logic [IW-1:0] base);
      drive(fl, en, dr, fsq, base);
      advance();
   endtask

   task automatic mid_reset();
      flush = 1'b0; enq_en = '0; deq_ready = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("async_reset count", count, 0);
      chk("async_reset deq_valid", deq_valid, 0);
      chk("async_reset enq_ready", enq_ready, 1);
      q.delete();
      ready_m = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic           fl;
      logic [ENQ-1:0] en;
      logic           dr;
      int             cnt;
      logic           rdy;
      logic [DEQ-1:0] val;
      logic [IW-1:0]  inst0;
      logic [11:0]    off;
   } vec_t;

   localparam int NV = 19;
   vec_t tbl [NV];

   initial begin
      logic [11:0] m;

      // Expected columns are the outputs seen during that row, before its edge.
      // Row r drives inst = r*256 + slot and fsqIdx = r.
      tbl[0]  = '{1'b0, 8'hB1, 1'b1,  0, 1'b1, 4'h0, 32'h000, 12'h000};
      tbl[1]  = '{1'b0, 8'h00, 1'b1,  4, 1'b1, 4'hF, 32'h000, 12'hF60};
      tbl[2]  = '{1'b0, 8'hFF, 1'b0,  0, 1'b1, 4'h0, 32'h000, 12'h000};
      tbl[3]  = '{1'b0, 8'hFF, 1'b0,  8, 1'b1, 4'hF, 32'h200, 12'h688};
      tbl[4]  = '{1'b0, 8'hFF, 1'b0, 16, 1'b1, 4'hF, 32'h200, 12'h688};
      tbl[5]  = '{1'b0, 8'hFF, 1'b0, 24, 1'b1, 4'hF, 32'h200, 12'h688};
      tbl[6]  = '{1'b0, 8'hFF, 1'b0, 32, 1'b0, 4'hF, 32'h200, 12'h688};
      tbl[7]  = '{1'b0, 8'h00, 1'b1, 32, 1'b0, 4'hF, 32'h200, 12'h688};
      tbl[8]  = '{1'b0, 8'h00, 1'b1, 28, 1'b0, 4'hF, 32'h204, 12'hFAC};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 24, 1'b1, 4'hF, 32'h300, 12'h688};
      tbl[10] = '{1'b1, 8'hFF, 1'b1, 24, 1'b1, 4'hF, 32'h300, 12'h688};
      tbl[11] = '{1'b0, 8'h00, 1'b1,  0, 1'b1, 4'h0, 32'h000, 12'h000};
      tbl[12] = '{1'b0, 8'h07, 1'b0,  0, 1'b1, 4'h0, 32'h000, 12'h000};
      tbl[13] = '{1'b0, 8'h07, 1'b0,  3, 1'b1, 4'h7, 32'hC00, 12'h088};
      tbl[14] = '{1'b0, 8'h92, 1'b1,  6, 1'b1, 4'hF, 32'hC00, 12'h088};
      tbl[15] = '{1'b0, 8'h00, 1'b0,  5, 1'b1, 4'hF, 32'hD01, 12'h851};
      tbl[16] = '{1'b0, 8'h00, 1'b1,  5, 1'b1, 4'hF, 32'hD01, 12'h851};
      tbl[17] = '{1'b0, 8'h00, 1'b1,  1, 1'b1, 4'h1, 32'hE07, 12'h007};
      tbl[18] = '{1'b0, 8'h00, 1'b0,  0, 1'b1, 4'h0, 32'h000, 12'h000};

      #2 rst = 1'b0;
      #2;
      chk("reset count", count, 0);
      chk("reset deq_valid", deq_valid, 0);
      chk("reset enq_ready", enq_ready, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int r = 0; r < NV; r++) begin
         drive(tbl[r].fl, tbl[r].en, tbl[r].dr, XW'(r), IW'(r) << 8);
`ifndef IBUF_BYPASS_EN
         chk($sformatf("row%0d count", r), count, tbl[r].cnt);
         chk($sformatf("row%0d enq_ready", r), enq_ready, tbl[r].rdy);
         chk($sformatf("row%0d deq_valid", r), deq_valid, tbl[r].val);
         if (tbl[r].val[0])
            chk($sformatf("row%0d deq_inst0", r), deq_inst[IW-1:0], tbl[r].inst0);
         for (int i = 0; i < DEQ; i++) m[i*3 +: 3] = {3{tbl[r].val[i]}};
         chk($sformatf("row%0d deq_offset", r), deq_offset & m, tbl[r].off);
`endif
         advance();
      end

`ifdef IBUF_BYPASS_EN
      // Empty queue, 6-instruction block: first four leave in the same cycle.
      drive(1'b0, 8'h3F, 1'b1, 4'h5, 32'hB00);
      chk("bypass deq_valid", deq_valid, 4'hF);
      chk("bypass deq_inst0", deq_inst[IW-1:0], 32'hB00);
      chk("bypass deq_inst3", deq_inst[3*IW +: IW], 32'hB03);
      advance();
      drive(1'b0, 8'h00, 1'b0, 4'h0, 32'h0);
      chk("bypass rest count", count, 2);
      chk("bypass rest deq_valid", deq_valid, 4'h3);
      chk("bypass rest offsets", deq_offset[5:0], {3'd5, 3'd4});
      advance();
      step(1'b0, 8'h00, 1'b1, 4'h0, 32'h0);
`endif

      // Walk both pointers to slot 30, then enqueue a block that straddles the wrap.
      step(1'b1, 8'h00, 1'b0, 4'h0, 32'h0);
      step(1'b0, 8'h01, 1'b0, 4'h1, 32'h1000);
      for (int i = 0; i < 29; i++) step(1'b0, 8'h01, 1'b1, 4'h2, 32'h2000 + IW'(i << 4));
      step(1'b0, 8'h00, 1'b1, 4'h0, 32'h0);
      step(1'b0, 8'hFF, 1'b0, 4'h9, 32'h9000);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 4'h0, 32'h0);

      // Randomized traffic, including dropped enqueues and two async resets.
      for (int c = 0; c < 800; c++) begin
         logic [ENQ-1:0] en;
         if (c == 300 || c == 650) mid_reset();
         case ($urandom_range(0, 3))
            0:       en = 8'hFF;
            1:       en = '0;
            default: en = ENQ'($urandom);
         endcase
         step($urandom_range(0, 99) < 3, en, $urandom_range(0, 99) < 60,
              XW'($urandom), $urandom);
      end

      $display("protocol: %0d enqueue attempts made while enq_ready=0 were dropped", drops);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
